// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State encoding, default cycle counts and saturating count helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUNNING   = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 10000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer, synchronous active-high reset.
// Both stages reset to 0 so a lock input reads as "not locked" after reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values for the two stages: plain shift toward the output.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer on the board reference clock: pulses the PLL reset, waits for and qualifies lock.
// Optional macro PLL_SEQ_AUTO_RECOVER_EN: lock loss while running restarts automatically instead of parking in FAULT.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] retry_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic locked_s;

    seq_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [7:0]       loss_d, loss_q;
    logic [7:0]       retry_d, retry_q;
    logic             pll_rst_d, pll_rst_q;
    logic             sys_rst_d, sys_rst_q;
    logic             ready_d, ready_q;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next state, shared cycle counter and event counts; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        retry_d = retry_q;

        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d   = '0;
                    retry_d = sat_inc8(retry_q);
                    state_d = RESET_PLL;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    cnt_d   = '0;
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    cnt_d   = '0;
                    state_d = RUNNING;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUNNING: begin
                if (!locked_s) begin
                    cnt_d  = '0;
                    loss_d = sat_inc8(loss_q);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                    state_d = RESET_PLL;
`else
                    state_d = FAULT;
`endif
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d   = '0;
                state_d = RESET_PLL;
            end
        endcase

        // Software restart overrides any transition; event counts above still land.
        if (sw_restart) begin
            cnt_d   = '0;
            state_d = RESET_PLL;
        end

        pll_rst_d = (state_d == RESET_PLL);
        sys_rst_d = (state_d != RUNNING);
        ready_d   = (state_d == RUNNING);
    end

    // Sequencer state, counter, counts and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            loss_q    <= 8'd0;
            retry_q   <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short cycle parameters.
// Directed scenarios plus random lock/restart traffic against a phase/elapsed-time model.
module tb_pll_reset_sequencer;

    localparam int RSTC = 4;
    localparam int TMO  = 20;
    localparam int STC  = 8;

    localparam int P_RST = 0;
    localparam int P_WT  = 1;
    localparam int P_STB = 2;
    localparam int P_RUN = 3;
    localparam int P_FLT = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RSTC),
        .LOCK_TIMEOUT  (TMO),
        .STABLE_CYCLES (STC),
        .CNT_W         (16)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_restart    (sw_restart),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase, cycles spent in it, event counts and the lock delay line.
    typedef struct {
        int phase;
        int elapsed;
        int retry;
        int loss;
        bit lk1;
        bit lk2;
    } model_t;

    model_t m;

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic model_t next_model(input model_t c, input bit r,
                                          input bit lk, input bit swr);
        model_t n;
        n = c;
        if (r) begin
            n = '{phase: P_RST, elapsed: 0, retry: 0, loss: 0, lk1: 0, lk2: 0};
            return n;
        end
        n.lk1 = lk;
        n.lk2 = c.lk1;
        case (c.phase)
            P_RST: begin
                n.elapsed = c.elapsed + 1;
                if (n.elapsed == RSTC) begin
                    n.phase = P_WT;
                    n.elapsed = 0;
                end
            end
            P_WT: begin
                if (c.lk2) begin
                    n.phase = P_STB;
                    n.elapsed = 0;
                end else begin
                    n.elapsed = c.elapsed + 1;
                    if (n.elapsed == TMO) begin
                        n.retry = sat(c.retry);
                        n.phase = P_RST;
                        n.elapsed = 0;
                    end
                end
            end
            P_STB: begin
                if (!c.lk2) begin
                    n.phase = P_WT;
                    n.elapsed = 0;
                end else begin
                    n.elapsed = c.elapsed + 1;
                    if (n.elapsed == STC) begin
                        n.phase = P_RUN;
                        n.elapsed = 0;
                    end
                end
            end
            P_RUN: begin
                if (!c.lk2) begin
                    n.loss = sat(c.loss);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                    n.phase = P_RST;
`else
                    n.phase = P_FLT;
`endif
                    n.elapsed = 0;
                end
            end
            default: ;
        endcase
        if (swr) begin
            n.phase = P_RST;
            n.elapsed = 0;
        end
        return n;
    endfunction

    always @(posedge refclk) m <= next_model(m, rst, pll_locked, sw_restart);

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge refclk);
        chk("m_pll_rst", {7'd0, pll_rst}, {7'd0, m.phase == P_RST});
        chk("m_sys_rst", {7'd0, sys_rst}, {7'd0, m.phase != P_RUN});
        chk("m_ready", {7'd0, ready}, {7'd0, m.phase == P_RUN});
        chk("m_loss", lock_loss_cnt, 8'(m.loss));
        chk("m_retry", retry_cnt, 8'(m.retry));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, {7'd0, pll_rst}, 8'd1);
        chk({tag, "_sys_rst"}, {7'd0, sys_rst}, 8'd1);
        chk({tag, "_ready"}, {7'd0, ready}, 8'd0);
        chk({tag, "_loss"}, lock_loss_cnt, 8'd0);
        chk({tag, "_retry"}, retry_cnt, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        sw_restart = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
    endtask

    task automatic wait_pll_rst_low(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (pll_rst === 1'b1 && n < 200);
        chk("pll_rst_fall_in_bound", {7'd0, n < 200}, 8'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ready !== 1'b1 && n < 200);
        chk("ready_in_bound", {7'd0, n < 200}, 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cycles;
        int hold;

        // Nominal bring-up.
        do_reset();
        wait_pll_rst_low(n);
        chk("pll_rst_width", 8'(n), 8'(RSTC));
        repeat (5) tick();
        pll_locked = 1'b1;
        wait_ready(n);
        chk("lock_to_ready", 8'(n), 8'(1 + 2 + STC));
        chk("nominal_sys_rst", {7'd0, sys_rst}, 8'd0);
        chk("nominal_loss", lock_loss_cnt, 8'd0);
        chk("nominal_retry", retry_cnt, 8'd0);

        // Lock loss while running.
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("loss_ready_hold", {7'd0, ready}, 8'd1);
        tick();
        chk("loss_sys_rst", {7'd0, sys_rst}, 8'd1);
        chk("loss_ready", {7'd0, ready}, 8'd0);
        chk("loss_cnt", lock_loss_cnt, 8'd1);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
        chk("loss_pll_rst", {7'd0, pll_rst}, 8'd1);
        wait_pll_rst_low(n);
        repeat (5) tick();
        pll_locked = 1'b1;
        wait_ready(n);
        chk("rerun_lock_to_ready", 8'(n), 8'(1 + 2 + STC));
`else
        chk("fault_pll_rst", {7'd0, pll_rst}, 8'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("fault_hold_pll_rst", {7'd0, pll_rst}, 8'd0);
            chk("fault_hold_sys_rst", {7'd0, sys_rst}, 8'd1);
        end
        sw_restart = 1'b1;
        tick();
        sw_restart = 1'b0;
        chk("fault_exit_pll_rst", {7'd0, pll_rst}, 8'd1);
`endif

        // Glitch during qualification.
        do_reset();
        wait_pll_rst_low(n);
        pll_locked = 1'b1;
        repeat (7) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("glitch_ready", {7'd0, ready}, 8'd0);
        pll_locked = 1'b1;
        wait_ready(n);
        chk("glitch_requalify", 8'(n), 8'(1 + 2 + STC));
        chk("glitch_loss", lock_loss_cnt, 8'd0);
        chk("glitch_retry", retry_cnt, 8'd0);

        // Lock timeouts and retry saturation.
        do_reset();
        repeat (3 * (RSTC + TMO)) tick();
        chk("timeout_retry3", retry_cnt, 8'd3);
        chk("timeout_repulse", {7'd0, pll_rst}, 8'd1);
        repeat (300 * (RSTC + TMO)) tick();
        chk("timeout_retry_sat", retry_cnt, 8'd255);

        // rst while qualifying.
        do_reset();
        wait_pll_rst_low(n);
        pll_locked = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_in_stable");
        rst = 1'b0;

        // sw_restart on the same cycle lock is first seen.
        do_reset();
        wait_pll_rst_low(n);
        pll_locked = 1'b1;
        repeat (2) tick();
        sw_restart = 1'b1;
        tick();
        sw_restart = 1'b0;
        chk("swr_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("swr_sys_rst", {7'd0, sys_rst}, 8'd1);

        // Random lock traffic with occasional restarts and resets.
        do_reset();
        cycles = 0;
        while (cycles < 2500) begin
            pll_locked = ~pll_locked;
            hold = pll_locked ? int'($urandom_range(5, 60))
                              : int'($urandom_range(1, 25));
            for (int k = 0; k < hold; k++) begin
                sw_restart = ($urandom_range(0, 79) == 0);
                rst = ($urandom_range(0, 599) == 0);
                tick();
                cycles++;
            end
        end
        sw_restart = 1'b0;
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the PLL reset input and consumes the PLL lock output.
- Sequences PLL reset, waits for lock with a timeout and retry, and qualifies lock as stable before releasing system reset.
- On loss of lock, re-asserts system reset and restarts the PLL.
- Runs on the free-running board reference clock, not on any PLL output. Sits between the board clock input and the PLL wrapper.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 10000: cycles to wait for lock before retry (1 ms at 10 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles needed before release.
- CNT_W, 16: shared cycle counter width; must satisfy 2^CNT_W > max of the three above.

Ports:
- refclk  input  1  board reference clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- pll_locked  input  1  PLL lock, asynchronous to refclk.
- sw_restart  input  1  single-cycle request to rerun the full sequence.
- pll_rst  output  1  PLL reset, active high.
- sys_rst  output  1  downstream reset, active high.
- ready  output  1  high only in RUNNING.
- lock_loss_cnt  output  8  saturating count of RUNNING-to-lock-loss events.
- retry_cnt  output  8  saturating count of lock timeouts.

Behaviour:
- pll_locked passes through a 2-flop synchronizer (locked_s) before any use. Synchronizer flops reset to 0.
- Reset values while rst=1: state=RESET_PLL, counter=0, pll_rst=1, sys_rst=1, ready=0, lock_loss_cnt=0, retry_cnt=0. Reset mid-operation aborts any state immediately.
- All outputs are registered.
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Counter increments each cycle. At counter==RST_CYCLES-1: counter<=0, go to WAIT_LOCK, pll_rst<=0.
  - pll_rst is therefore high for exactly RST_CYCLES cycles after rst drops.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1; counter increments.
  - If locked_s=1: counter<=0, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1: retry_cnt++ (saturate at 255), counter<=0, go to RESET_PLL.
  - If locked_s=1 on the timeout cycle, lock wins.
- STABLE:
  - sys_rst=1. Counter increments while locked_s=1.
  - If locked_s=0: counter<=0, go to WAIT_LOCK. The timeout restarts; no count changes.
  - At counter==STABLE_CYCLES-1 with locked_s=1: go to RUNNING. sys_rst<=0 and ready<=1 on that same edge.
- RUNNING:
  - sys_rst=0, ready=1.
  - If locked_s=0: lock_loss_cnt++ (saturating), go to RESET_PLL. sys_rst<=1, ready<=0, pll_rst<=1 on the same edge.
- sw_restart:
  - Sampled in every state: go to RESET_PLL, counter<=0, sys_rst<=1, ready<=0.
  - No counter increments for sw_restart.
  - If sw_restart and lock loss coincide in RUNNING: lock_loss_cnt still increments, then the restart occurs.
- Counter never wraps. It is cleared on every state transition.
- Counts hold their values across restarts and clear only on rst.

Optional Feature:
- Macro: PLL_SEQ_AUTO_RECOVER_EN.
- Defined: lock loss in RUNNING restarts automatically, as above.
- Undefined:
  - Lock loss in RUNNING goes to FAULT: pll_rst=0, sys_rst=1, ready=0, state held.
  - Only sw_restart or rst leaves FAULT, going to RESET_PLL.
  - lock_loss_cnt still increments on entry to FAULT.
  - Timeout retries in WAIT_LOCK are unaffected.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUNNING, FAULT}, 3-bit encoding;
  - default cycle constants;
  - saturating-increment function for the 8-bit counts.
- One sub-module, sync_2ff: a generic 2-flop bit synchronizer with synchronous reset, reused by other cross-domain inputs.

Test Plan (bench overrides: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8):
- Nominal: release rst, raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 2+8 edges after pll_locked first sampled high; counts stay 0.
- Timeout: hold pll_locked=0 -> pll_rst re-pulses 4 cycles every 24 cycles; retry_cnt increments 1,2,3; after 300 timeouts retry_cnt=255.
- Glitch in STABLE: drop pll_locked for 3 cycles mid-qualification -> return to WAIT_LOCK; ready stays 0; qualification restarts from 0; no count changes.
- Lock loss in RUNNING, macro defined: drop pll_locked -> 2 cycles later sys_rst=1, ready=0, pll_rst=1, lock_loss_cnt=1; full sequence reruns to ready.
- Lock loss, macro undefined: state FAULT; pll_rst stays 0 and sys_rst stays 1 for 100 cycles; sw_restart pulse -> pll_rst high next edge.
- Reset/restart corners:
  - rst asserted in STABLE -> next edge all outputs at reset values and both counts 0.
  - sw_restart pulsed in WAIT_LOCK on the same cycle locked_s rises -> RESET_PLL taken.
